time_of_day_counter: RTL



---
 rtl/time_of_day_counter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/time_of_day_counter.sv
// 24-hour hh:mm:ss BCD time-of-day counter driven by a synchronous tick input,
// with a RUN / SET_HR / SET_MIN push-button adjust mode.
module time_of_day_counter #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [1:0] hr_tens,
  output logic [1:0] mode,
  output logic       sec_pulse
);

  localparam int unsigned PresW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetHr  = 2'd1,
    StSetMin = 2'd2
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [PresW-1:0] pres_q, pres_d;
  logic             tick_q, mode_btn_q, inc_btn_q;
  logic             sec_pulse_q, sec_pulse_d;
  logic [3:0]       sec_ones_q, sec_ones_d, min_ones_q, min_ones_d, hr_ones_q, hr_ones_d;
  logic [2:0]       sec_tens_q, sec_tens_d, min_tens_q, min_tens_d;
  logic [1:0]       hr_tens_q, hr_tens_d;

  logic tick_rise, mode_rise, inc_rise, sec_event;
  logic advance, hr_inc, min_inc, clear_sec;
  logic sec_wrap, min_wrap, step_min, step_hr;

  assign tick_rise = tick_in & ~tick_q;
  assign mode_rise = mode_btn & ~mode_btn_q;
  assign inc_rise  = inc_btn & ~inc_btn_q;
  assign sec_event = tick_rise && (pres_q == PresMax);

  assign sec_wrap = (sec_ones_q == 4'd9) && (sec_tens_q == 3'd5);
  assign min_wrap = (min_ones_q == 4'd9) && (min_tens_q == 3'd5);

  always_comb begin
    mode_d    = mode_q;
    advance   = 1'b0;
    hr_inc    = 1'b0;
    min_inc   = 1'b0;
    clear_sec = 1'b0;
    // A mode rise always takes priority over a simultaneous inc rise.
    unique case (mode_q)
      StRun: begin
        advance = sec_event;
        if (mode_rise) mode_d = StSetHr;
      end
      StSetHr: begin
        if (mode_rise) mode_d = StSetMin;
        else if (inc_rise) hr_inc = 1'b1;
      end
      StSetMin: begin
        if (mode_rise) begin
          mode_d    = StRun;
          clear_sec = 1'b1;
        end else if (inc_rise) begin
          min_inc = 1'b1;
        end
      end
      default: mode_d = StRun;
    endcase
  end

  assign step_min = min_inc | (advance & sec_wrap);
  assign step_hr  = hr_inc | (advance & sec_wrap & min_wrap);

  always_comb begin
    sec_pulse_d = sec_event;
    pres_d      = pres_q;
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    hr_ones_d   = hr_ones_q;
    hr_tens_d   = hr_tens_q;

    if (tick_rise) pres_d = sec_event ? '0 : pres_q + 1'b1;

    if (advance) begin
      if (sec_ones_q == 4'd9) begin
        sec_ones_d = 4'd0;
        sec_tens_d = (sec_tens_q == 3'd5) ? 3'd0 : sec_tens_q + 3'd1;
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end

    if (step_min) begin
      if (min_ones_q == 4'd9) begin
        min_ones_d = 4'd0;
        min_tens_d = (min_tens_q == 3'd5) ? 3'd0 : min_tens_q + 3'd1;
      end else begin
        min_ones_d = min_ones_q + 4'd1;
      end
    end

    if (step_hr) begin
      if (hr_tens_q == 2'd2 && hr_ones_q == 4'd3) begin
        hr_ones_d = 4'd0;
        hr_tens_d = 2'd0;
      end else if (hr_ones_q == 4'd9) begin
        hr_ones_d = 4'd0;
        hr_tens_d = hr_tens_q + 2'd1;
      end else begin
        hr_ones_d = hr_ones_q + 4'd1;
      end
    end

    // Leaving SET_MIN restarts the minute cleanly; any coincident second is dropped.
    if (clear_sec) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 3'd0;
      pres_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= StRun;
      pres_q      <= '0;
      tick_q      <= 1'b0;
      mode_btn_q  <= 1'b0;
      inc_btn_q   <= 1'b0;
      sec_pulse_q <= 1'b0;
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 3'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 3'd0;
      hr_ones_q   <= 4'd0;
      hr_tens_q   <= 2'd0;
    end else begin
      mode_q      <= mode_d;
      pres_q      <= pres_d;
      tick_q      <= tick_in;
      mode_btn_q  <= mode_btn;
      inc_btn_q   <= inc_btn;
      sec_pulse_q <= sec_pulse_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      hr_ones_q   <= hr_ones_d;
      hr_tens_q   <= hr_tens_d;
    end
  end

  assign sec_ones  = sec_ones_q;
  assign sec_tens  = sec_tens_q;
  assign min_ones  = min_ones_q;
  assign min_tens  = min_tens_q;
  assign hr_ones   = hr_ones_q;
  assign hr_tens   = hr_tens_q;
  assign mode      = mode_q;
  assign sec_pulse = sec_pulse_q;

endmodule
